// File: rtl/segment_display_mux_if.sv
// Load-side bundle for segment_display_mux.
// master drives glyphs/controls, slave reports pending.
interface segment_display_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  logic                    load;
  logic [5*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [PWM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    pending;

  modport master (
    output load, digits, dp,
    output brightness, blink_mask,
    input  pending
  );

  modport slave (
    input  load, digits, dp,
    input  brightness, blink_mask,
    output pending
  );
endinterface

// File: rtl/segment_display_mux.sv
// Multiplexed 7-seg driver: tear-free frames, PWM dimming.
// Blinking is built only when SEG_BLINK_EN is defined.
module segment_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 262144,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 48
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  segment_display_mux_if.slave  bus,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  dp_out
);
  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int SCAN_W = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST =
    SCAN_W'(NUM_DIGITS - 1);
  localparam logic [4:0] BLANK = 5'h1F;

  logic [SLOT_W-1:0]     slot_cnt;
  logic [SCAN_W-1:0]     scan;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [SCAN_W-1:0]     act;

  logic [4:0]            disp_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [4:0]            pend_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_q;

  logic                  blink_off;
  logic                  an_en;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            led_next;
  logic                  dp_next;

  function automatic logic [6:0] glyph(
    input logic [4:0] code
  );
    case (code)
      5'h00:   glyph = 7'b0000001;
      5'h01:   glyph = 7'b1001111;
      5'h02:   glyph = 7'b0010010;
      5'h03:   glyph = 7'b0000110;
      5'h04:   glyph = 7'b1001100;
      5'h05:   glyph = 7'b0100100;
      5'h06:   glyph = 7'b0100000;
      5'h07:   glyph = 7'b0001111;
      5'h08:   glyph = 7'b0000000;
      5'h09:   glyph = 7'b0000100;
      5'h0A:   glyph = 7'b0001000;
      5'h0B:   glyph = 7'b1100000;
      5'h0C:   glyph = 7'b0110001;
      5'h0D:   glyph = 7'b1000010;
      5'h0E:   glyph = 7'b0110000;
      5'h0F:   glyph = 7'b0111000;
      5'h11:   glyph = 7'b1000001;
      5'h12:   glyph = 7'b1111001;
      5'h13:   glyph = 7'b1110001;
      5'h14:   glyph = 7'b0000001;
      5'h15:   glyph = 7'b0001000;
      5'h16:   glyph = 7'b1100010;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign slot_wrap  = slot_cnt == SLOT_LAST;
  assign frame_wrap = slot_wrap && (scan == SCAN_LAST);
  // scan 0 drives the leftmost (highest-numbered) digit
  assign act        = SCAN_LAST - scan;

  // slot, scan and PWM counters; scan steps once per slot
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      slot_cnt <= '0;
      scan     <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_wrap) begin
        slot_cnt <= '0;
        scan     <= frame_wrap ? '0 : scan + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // pending/display buffers; display changes only at frame wrap
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      pend_q  <= 1'b0;
      pend_dp <= '0;
      disp_dp <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_code[i] <= BLANK;
        disp_code[i] <= BLANK;
      end
    end else if (frame_wrap) begin
      pend_q <= 1'b0;
      if (bus.load) begin
        disp_dp <= bus.dp;
        for (int i = 0; i < NUM_DIGITS; i++)
          disp_code[i] <= bus.digits[5*i +: 5];
      end else if (pend_q) begin
        disp_dp <= pend_dp;
        for (int i = 0; i < NUM_DIGITS; i++)
          disp_code[i] <= pend_code[i];
      end
    end else if (bus.load) begin
      pend_q  <= 1'b1;
      pend_dp <= bus.dp;
      for (int i = 0; i < NUM_DIGITS; i++)
        pend_code[i] <= bus.digits[5*i +: 5];
    end
  end

  assign bus.pending = pend_q;

`ifdef SEG_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST =
    BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // blink phase flips every BLINK_FRAMES frame wraps
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase & bus.blink_mask[act];
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink_mask;
  assign blink_off    = 1'b0;
`endif

  // next anode/cathode values for the active digit
  always_comb begin
    an_en = ((&bus.brightness) ||
             (pwm_cnt < bus.brightness)) && !blink_off;
    an_next      = '1;
    an_next[act] = ~an_en;
    led_next     = glyph(disp_code[act]);
    dp_next      = ~(an_en & disp_dp[act]);
  end

  // registered pins, one clock behind slot/scan state
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      Anode_Activate <= '1;
      LED_out        <= '1;
      dp_out         <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      Anode_Activate <= an_next;
      LED_out        <= led_next;
      dp_out         <= dp_next;
      frame_start    <= (scan == '0) && (slot_cnt == '0);
    end
  end
endmodule

// File: doc/segment_display_mux.md
SEGMENT_DISPLAY_MUX -- requirements
Module: segment_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter DIGIT_CYCLES, default 262144: clocks per digit slot (2.62 ms at 100 MHz), minimum 4.
REQ-003 SHALL have parameter PWM_BITS, default 4: brightness resolution.
REQ-004 SHALL have parameter BLINK_FRAMES, default 48: frames per blink half-period, minimum 1.
REQ-005 SHALL have port clock_100Mhz, input, width 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port load, input, width 1: captures digits and dp into the pending buffer.
REQ-008 SHALL have port digits, input, width 5*NUM_DIGITS: digit d glyph code in bits [5d+4:5d]; d=NUM_DIGITS-1 is leftmost.
REQ-009 SHALL have port dp, input, width NUM_DIGITS: per-digit decimal point, 1 = lit.
REQ-010 SHALL have port brightness, input, width PWM_BITS: 0 = dark, all-ones = full on.
REQ-011 SHALL have port blink_mask, input, width NUM_DIGITS: 1 = digit blinks.
REQ-012 SHALL have port pending, output, width 1: high while a captured load awaits application.
REQ-013 SHALL have port frame_start, output, width 1: one-cycle pulse at each frame boundary.
REQ-014 SHALL have port Anode_Activate, output, width NUM_DIGITS: active-low digit enables.
REQ-015 SHALL have port LED_out, output, width 7: active-low cathodes, bit6 = a through bit0 = g.
REQ-016 SHALL have port dp_out, output, width 1: active-low decimal point.

Function
REQ-017 Slot counter SHALL count 0..DIGIT_CYCLES-1 and wrap; on wrap, scan index s SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-018 Active digit SHALL be d = NUM_DIGITS-1-s; only Anode_Activate[d] may be low.
REQ-019 Glyph decode: codes 0x00-0x0F hex 0-F; 0x11 U, 0x12 I, 0x13 L, 0x14 O, 0x15 A, 0x16 o; 0x1F and all other codes blank (1111111).
REQ-020 Hex patterns SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 Letter patterns SHALL be: U=1000001, I=1111001, L=1110001, O=0000001, A=0001000, o=1100010.
REQ-022 All outputs SHALL be registered; Anode_Activate, LED_out and dp_out lag slot/scan state by exactly one clock.
REQ-023 Free-running PWM_BITS counter p SHALL increment every clock; the anode SHALL be enabled only when brightness is all-ones or p < brightness.
REQ-024 Anodes disabled by PWM or blink SHALL still present the glyph on LED_out; dp_out low only when the anode is enabled and the active digit's dp bit is 1.
REQ-025 Frame boundary SHALL be the cycle in which s wraps to 0; the display buffer SHALL update only there, giving tear-free frames.
REQ-026 load SHALL capture digits and dp into the pending buffer and set pending the next clock; a load while pending is high SHALL overwrite it (last wins).
REQ-027 At a frame boundary with pending high, the pending buffer SHALL be copied to the display buffer and pending SHALL clear.
REQ-028 A load in the boundary cycle SHALL be applied directly at that boundary; pending SHALL stay low.
REQ-029 frame_start SHALL pulse high for one clock, coincident with the first output cycle of s = 0.

Reset
REQ-030 On reset, the slot counter, s, p, blink counter and blink phase SHALL go to 0.
REQ-031 On reset, pending SHALL clear, the display buffer SHALL load all 0x1F with dp all 0, and Anode_Activate, LED_out and dp_out SHALL be all-ones.
REQ-032 On reset, frame_start SHALL be 0; reset mid-frame SHALL discard any pending load.

Configuration
REQ-033 With SEG_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame boundaries.
REQ-034 With SEG_BLINK_EN defined and blink phase 1, digits whose blink_mask bit is 1 SHALL have their anode disabled; blink_mask SHALL be sampled live.
REQ-035 Without SEG_BLINK_EN, blink_mask SHALL remain a port but be ignored, and no blink logic SHALL be synthesised.

Verification (NUM_DIGITS=4, DIGIT_CYCLES=4, PWM_BITS=2, BLINK_FRAMES=2)
REQ-036 Reset then run one frame -> Anode_Activate sequence 0111, 1011, 1101, 1110, each held 4 clocks; LED_out=1111111 throughout; frame_start pulses every 16 clocks.
REQ-037 Mid-frame load digits={0x03,0x0A,0x11,0x1F}, brightness=3 -> pending high until boundary; next frame LED_out=0000110, 0001000, 1000001, 1111111.
REQ-038 Two loads (value 0x00.. then 0x08..) before a boundary -> only the second value is displayed; load in the boundary cycle -> applied that frame, pending stays 0.
REQ-039 brightness=1 -> anode low 1 of 4 clocks per slot; brightness=0 -> anodes never low and dp_out stays 1.
REQ-040 SEG_BLINK_EN, blink_mask=0001 -> digit 0 dark for frames 2-3, lit for frames 4-5; without the macro, always lit.
REQ-041 Reset asserted mid-slot with pending high -> next clock all outputs all-ones, pending 0, display buffer blank.
